// File: rtl/hb_interp2.sv
// Halfband interpolate-by-2: one pre-adder, one 19x25 multiplier, 48-bit accumulator.
// Define HB_INTERP_SAT_EN to clamp the even-phase output instead of wrapping it.
module hb_interp2 #(
  parameter logic signed [24:0] COEF0 = 25'sh0000413,
  parameter logic signed [24:0] COEF2 = 25'sh1FFE42B,
  parameter logic signed [24:0] COEF4 = 25'sh00097C7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic signed [17:0] s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic signed [17:0] m_data
);

  localparam int DATA_W = 18;
  localparam int COEF_W = 25;
  localparam int PRE_W  = DATA_W + 1;
  localparam int PROD_W = PRE_W + COEF_W;
  localparam int ACC_W  = 48;

  typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, OUT_A, OUT_B} state_t;

  state_t                    state, state_nxt;
  logic signed [DATA_W-1:0]  dly [6];
  logic signed [ACC_W-1:0]   acc_p1, acc_nxt;
  logic signed [DATA_W-1:0]  pa_p0, pb_p0;
  logic signed [COEF_W-1:0]  coef_p0;
  logic signed [PRE_W-1:0]   pre_p0;
  logic signed [PROD_W-1:0]  prod_p0;
  logic                      take;

  // Round half up at bit 15; the shift by 16 also applies the x2 interpolation gain.
  function automatic logic signed [31:0] rnd_q16(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] t;
    t = a + 48'sd32768;
    return 32'(t >>> 16);
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_out(input logic signed [31:0] y);
`ifdef HB_INTERP_SAT_EN
    if (y > 32'sd131071)
      return 18'sh1FFFF;
    else if (y < -32'sd131072)
      return 18'sh20000;
    else
      return DATA_W'(y);
`else
    return DATA_W'(y);
`endif
  endfunction

  assign take = s_valid && s_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = MAC0;
      MAC0:    state_nxt = MAC1;
      MAC1:    state_nxt = MAC2;
      MAC2:    state_nxt = OUT_A;
      OUT_A:   if (m_ready) state_nxt = OUT_B;
      OUT_B:   if (m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      s_ready <= (state_nxt == IDLE);
      if (state == MAC2)
        m_valid <= 1'b1;
      else if (state == OUT_B && m_ready)
        m_valid <= 1'b0;
    end
  end

  // Stage p0: symmetric tap pair selection, pre-add and multiply
  always_comb begin
    pa_p0   = '0;
    pb_p0   = '0;
    coef_p0 = '0;
    case (state)
      MAC0: begin pa_p0 = dly[0]; pb_p0 = dly[5]; coef_p0 = COEF0; end
      MAC1: begin pa_p0 = dly[1]; pb_p0 = dly[4]; coef_p0 = COEF2; end
      MAC2: begin pa_p0 = dly[2]; pb_p0 = dly[3]; coef_p0 = COEF4; end
      default: ;
    endcase
  end

  assign pre_p0  = PRE_W'(pa_p0) + PRE_W'(pb_p0);
  assign prod_p0 = PROD_W'(pre_p0) * PROD_W'(coef_p0);
  assign acc_nxt = acc_p1 + ACC_W'(prod_p0);

  // Stage p1: accumulator, delay line and registered output data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p1 <= '0;
      m_data <= '0;
      for (int k = 0; k < 6; k++) dly[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            dly[0] <= s_data;
            for (int k = 1; k < 6; k++) dly[k] <= dly[k-1];
            acc_p1 <= '0;
          end
        end
        MAC0, MAC1: acc_p1 <= acc_nxt;
        MAC2: begin
          acc_p1 <= acc_nxt;
          m_data <= sat_out(rnd_q16(acc_nxt));
        end
        OUT_A: if (m_ready) m_data <= dly[2];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hb_interp2.sv
// Bench for hb_interp2: random traffic against a sample-history model plus directed literal checks.
module tb_hb_interp2;

  localparam longint C0 = 1043;
  localparam longint C2 = -7125;
  localparam longint C4 = 38855;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0, s_ready;
  logic [17:0] s_data = '0;
  logic        m_valid, m_ready = 1'b0;
  logic [17:0] m_data;

  logic        s_valid2 = 1'b0, s_ready2;
  logic [17:0] s_data2 = '0;
  logic        m_valid2, m_ready2 = 1'b1;
  logic [17:0] m_data2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  longint      hist [6];
  logic [17:0] exp_q [$];
  logic [17:0] got_q [$];
  int          acc_cyc [$];
  int          mv_cyc = 0;
  bit          mv_seen = 1'b0;
  bit          stall_prev = 1'b0;
  logic [17:0] data_prev = '0;
  bit          running = 1'b0;

  logic [17:0] imp [12] = '{18'h00413, 18'h00000, 18'h3E42B, 18'h00000,
                            18'h097C7, 18'h10000, 18'h097C7, 18'h00000,
                            18'h3E42B, 18'h00000, 18'h00413, 18'h00000};

  always #5 clk = ~clk;

  hb_interp2 dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  hb_interp2 #(.COEF0(25'sh0000001)) dut_rnd (
    .clk(clk), .rst(rst),
    .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
    .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got no event want event", name);
  endtask

  // Even output: plain FIR over the six most recent inputs, rounded, x2 gain, reduced to 18 bits.
  function automatic logic [17:0] model_a();
    longint acc, ya;
    acc = C0 * (hist[0] + hist[5]) + C2 * (hist[1] + hist[4]) + C4 * (hist[2] + hist[3]);
    ya  = (acc + 32768) >>> 16;
`ifdef HB_INTERP_SAT_EN
    if (ya > 131071) ya = 131071;
    else if (ya < -131072) ya = -131072;
`endif
    return ya[17:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 6; k++) hist[k] = 0;
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, data_prev);
      end
      check("ready_valid_excl", s_ready && m_valid, 0);
      stall_prev = m_valid && !m_ready;
      data_prev  = m_data;
      if (s_valid && s_ready) begin
        for (int k = 5; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = longint'($signed(s_data));
        exp_q.push_back(model_a());
        exp_q.push_back(hist[2][17:0]);
        acc_cyc.push_back(cyc);
      end
      if (m_valid && !mv_seen) begin
        mv_seen = 1'b1;
        mv_cyc  = cyc;
      end
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        if (exp_q.size() == 0) fail_now("extra_output");
        else check("m_data", m_data, exp_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [17:0] d, input bit keep);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
    end
    #1;
    if (!keep) s_valid = 1'b0;
    s_data = 18'($urandom);
    if (!ok) fail_now("send_timeout");
  endtask

  task automatic wait_outs(input int n);
    for (int i = 0; i < 400 && got_q.size() < n; i++) @(posedge clk);
    #1;
    if (got_q.size() < n) fail_now("output_timeout");
  endtask

  function automatic logic [17:0] rand_sample();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return 18'h1FFFF;
    if (sel == 1) return 18'h20000;
    return 18'($urandom);
  endfunction

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    check("s_ready_after_rst", s_ready, 1);

    // Rounding on the COEF0=1 instance: acc=32768 -> ya=1, odd phase is zero history.
    check("rnd_s_ready", s_ready2, 1);
    s_valid2 = 1'b1; s_data2 = 18'h08000;
    @(posedge clk); #1 s_valid2 = 1'b0;
    for (int i = 0; i < 20 && !m_valid2; i++) begin @(posedge clk); #1; end
    check("rnd_a_valid", m_valid2, 1);
    check("rnd_a", m_data2, 1);
    @(posedge clk); #1;
    check("rnd_b_valid", m_valid2, 1);
    check("rnd_b", m_data2, 0);

    // Impulse response
    m_ready = 1'b1;
    got_q.delete();
    send(18'h10000, 1'b0);
    repeat (5) send(18'h00000, 1'b0);
    wait_outs(12);
    for (int i = 0; i < 12 && i < got_q.size(); i++) check($sformatf("impulse_%0d", i), got_q[i], imp[i]);

    // Latency and throughput with continuous s_valid
    do_reset();
    mv_seen = 1'b0;
    acc_cyc.delete();
    for (int i = 0; i < 8; i++) send(rand_sample(), 1'b1);
    s_valid = 1'b0;
    check("latency", mv_cyc - acc_cyc[0], 4);
    for (int i = 1; i < acc_cyc.size(); i++) check("accept_period", acc_cyc[i] - acc_cyc[i-1], 6);

    // DC full scale
    do_reset();
    got_q.delete();
    repeat (6) send(18'h1FFFF, 1'b0);
    wait_outs(12);
`ifdef HB_INTERP_SAT_EN
    check("dc_a", got_q[10], 18'h1FFFF);
`else
    check("dc_a", got_q[10], 18'h20013);
`endif
    check("dc_b", got_q[11], 18'h1FFFF);

    // Backpressure: stall 5 clocks in OUT_A and 3 clocks in OUT_B with s_valid held high
    got_q.delete();
    m_ready = 1'b0;
    send(rand_sample(), 1'b0);
    for (int i = 0; i < 20 && !m_valid; i++) begin @(posedge clk); #1; end
    check("bp_valid", m_valid, 1);
    s_valid = 1'b1; s_data = 18'h15555;
    repeat (5) begin @(posedge clk); #1; check("bp_a_s_ready", s_ready, 0); end
    m_ready = 1'b1;
    @(posedge clk); #1 m_ready = 1'b0;
    check("bp_one_out", got_q.size(), 1);
    repeat (3) begin @(posedge clk); #1; check("bp_b_s_ready", s_ready, 0); end
    s_valid = 1'b0;
    m_ready = 1'b1;
    wait_outs(2);
    check("bp_two_out", got_q.size(), 2);

    // Reset in MAC1 after an impulse; history must be cleared afterwards
    send(18'h10000, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_m_data", m_data, 0);
    check("midrst_s_ready", s_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    got_q.delete();
    send(18'h00000, 1'b0);
    wait_outs(2);
    check("midrst_a", got_q[0], 0);
    check("midrst_b", got_q[1], 0);

    // Random traffic with random backpressure
    do_reset();
    running = 1'b1;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          send(rand_sample(), 1'b0);
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
        running = 1'b0;
      end
      begin
        while (running) begin
          @(posedge clk); #1 m_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    m_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
